// File: rtl/jedro_1_lsu_pkg.sv
// jedro_1 load-store unit: shared types.
// Size and FSM state encodings, alignment helper.
package jedro_1_lsu_pkg;

  typedef enum logic [1:0] {
    LSU_SIZE_BYTE = 2'b00,
    LSU_SIZE_HALF = 2'b01,
    LSU_SIZE_WORD = 2'b10,
    LSU_SIZE_BAD  = 2'b11
  } lsu_size_e;

  typedef enum logic [1:0] {
    LSU_ST_IDLE = 2'b00,
    LSU_ST_REQ  = 2'b01,
    LSU_ST_RESP = 2'b10
  } lsu_state_e;

  // Requests that cannot go on the bus as a single beat.
  function automatic logic lsu_misaligned(
    input lsu_size_e  size,
    input logic [1:0] off
  );
    logic bad;
    case (size)
      LSU_SIZE_BYTE: bad = 1'b0;
      LSU_SIZE_HALF: bad = off[0];
      LSU_SIZE_WORD: bad = |off;
      default:       bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/jedro_1_lsu_if.sv
// jedro_1 data-memory bus.
// req/gnt address phase, rvalid response phase.
interface jedro_1_lsu_if;
  logic        req;
  logic        gnt;
  logic        rvalid;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req, we, be, addr, wdata,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, we, be, addr, wdata,
    output gnt, rvalid, rdata, err
  );
endinterface

// File: rtl/jedro_1_lsu_align.sv
// jedro_1 LSU lane steering.
// Store byte enables/replication, load shift/extend.
module jedro_1_lsu_align
  import jedro_1_lsu_pkg::*;
(
  input  lsu_size_e   st_size,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_wdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  input  lsu_size_e   ld_size,
  input  logic [1:0]  ld_off,
  input  logic        ld_unsigned,
  input  logic [31:0] rdata,
  output logic [31:0] ld_data
);

  logic [31:0] shifted;
  logic        sgn;

  // Store side: lane enables and replicated data.
  always_comb begin
    be    = 4'b0000;
    wdata = st_wdata;
    case (st_size)
      LSU_SIZE_BYTE: begin
        be    = 4'b0001 << st_off;
        wdata = {4{st_wdata[7:0]}};
      end
      LSU_SIZE_HALF: begin
        be    = 4'b0011 << st_off;
        wdata = {2{st_wdata[15:0]}};
      end
      LSU_SIZE_WORD: be = 4'b1111;
      default:       be = 4'b0000;
    endcase
  end

  assign shifted = rdata >> {ld_off, 3'b000};

  // Load side: extract lane and extend.
  always_comb begin
    sgn     = 1'b0;
    ld_data = shifted;
    case (ld_size)
      LSU_SIZE_BYTE: begin
        sgn     = ~ld_unsigned & shifted[7];
        ld_data = {{24{sgn}}, shifted[7:0]};
      end
      LSU_SIZE_HALF: begin
        sgn     = ~ld_unsigned & shifted[15];
        ld_data = {{16{sgn}}, shifted[15:0]};
      end
      default: ld_data = shifted;
    endcase
  end

endmodule

// File: rtl/jedro_1_lsu.sv
// jedro_1 load-store unit.
// One outstanding bus transaction, aligned write-back.
module jedro_1_lsu
  import jedro_1_lsu_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic                      ctrl_valid_i,
  input  logic                      ctrl_we_i,
  input  logic [1:0]                ctrl_size_i,
  input  logic                      ctrl_unsigned_i,
  input  logic [REG_ADDR_WIDTH-1:0] ctrl_rd_i,
  input  logic [31:0]               addr_i,
  input  logic [DATA_WIDTH-1:0]     wdata_i,
  output logic                      ready_o,
  output logic                      done_o,
  output logic [DATA_WIDTH-1:0]     rdata_o,
  output logic                      rdata_valid_o,
  output logic [REG_ADDR_WIDTH-1:0] rd_addr_o,
  output logic                      misaligned_o,
  output logic                      bus_err_o,
  jedro_1_lsu_if.master             data
);

  lsu_state_e                state;
  lsu_size_e                 size_in;
  lsu_size_e                 size_q;
  logic                      we_q;
  logic                      uns_q;
  logic [1:0]                off_q;
  logic [REG_ADDR_WIDTH-1:0] rd_q;
  logic [3:0]                be_w;
  logic [31:0]               wdata_w;
  logic [31:0]               ld_data;

  assign size_in = lsu_size_e'(ctrl_size_i);
  assign ready_o = (state == LSU_ST_IDLE);

  jedro_1_lsu_align u_align (
    .st_size     (size_in),
    .st_off      (addr_i[1:0]),
    .st_wdata    (wdata_i),
    .be          (be_w),
    .wdata       (wdata_w),
    .ld_size     (size_q),
    .ld_off      (off_q),
    .ld_unsigned (uns_q),
    .rdata       (data.rdata),
    .ld_data     (ld_data)
  );

  // Transaction FSM with registered bus and result outputs.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state         <= LSU_ST_IDLE;
      size_q        <= LSU_SIZE_BYTE;
      we_q          <= 1'b0;
      uns_q         <= 1'b0;
      off_q         <= 2'b00;
      rd_q          <= '0;
      done_o        <= 1'b0;
      rdata_o       <= '0;
      rdata_valid_o <= 1'b0;
      rd_addr_o     <= '0;
      misaligned_o  <= 1'b0;
      bus_err_o     <= 1'b0;
      data.req      <= 1'b0;
      data.we       <= 1'b0;
      data.be       <= 4'b0000;
      data.addr     <= 32'h0;
      data.wdata    <= 32'h0;
    end else begin
      done_o        <= 1'b0;
      rdata_valid_o <= 1'b0;
      misaligned_o  <= 1'b0;
      bus_err_o     <= 1'b0;
      unique case (state)
        LSU_ST_IDLE: begin
          if (ctrl_valid_i) begin
            if (lsu_misaligned(size_in, addr_i[1:0])) begin
              misaligned_o <= 1'b1;
            end else begin
              state      <= LSU_ST_REQ;
              we_q       <= ctrl_we_i;
              size_q     <= size_in;
              uns_q      <= ctrl_unsigned_i;
              off_q      <= addr_i[1:0];
              rd_q       <= ctrl_rd_i;
              data.req   <= 1'b1;
              data.we    <= ctrl_we_i;
              data.be    <= be_w;
              data.addr  <= {addr_i[31:2], 2'b00};
              data.wdata <= wdata_w;
            end
          end
        end
        LSU_ST_REQ: begin
          if (data.gnt) begin
            data.req <= 1'b0;
            state    <= LSU_ST_RESP;
          end
        end
        LSU_ST_RESP: begin
          if (data.rvalid) begin
            state  <= LSU_ST_IDLE;
            done_o <= 1'b1;
            if (data.err) begin
              bus_err_o <= 1'b1;
            end else if (!we_q) begin
              rdata_valid_o <= 1'b1;
              rdata_o       <= ld_data;
              rd_addr_o     <= rd_q;
            end
          end
        end
        default: state <= LSU_ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jedro_1_lsu.sv
// Directed bench for jedro_1_lsu.
// Hand-computed expectations, immediate assertions.
module tb_jedro_1_lsu;

  logic        clk = 1'b0;
  logic        rstn;
  logic        valid;
  logic        we;
  logic [1:0]  size;
  logic        uns;
  logic [4:0]  rd;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic        done;
  logic [31:0] rdata;
  logic        rvalid_wb;
  logic [4:0]  rd_addr;
  logic        misal;
  logic        berr;

  int vectors = 0;
  int miscompares = 0;

  jedro_1_lsu_if mem ();

  jedro_1_lsu #(
    .DATA_WIDTH     (32),
    .REG_ADDR_WIDTH (5)
  ) dut (
    .clk_i           (clk),
    .rstn_i          (rstn),
    .ctrl_valid_i    (valid),
    .ctrl_we_i       (we),
    .ctrl_size_i     (size),
    .ctrl_unsigned_i (uns),
    .ctrl_rd_i       (rd),
    .addr_i          (addr),
    .wdata_i         (wdata),
    .ready_o         (ready),
    .done_o          (done),
    .rdata_o         (rdata),
    .rdata_valid_o   (rvalid_wb),
    .rd_addr_o       (rd_addr),
    .misaligned_o    (misal),
    .bus_err_o       (berr),
    .data            (mem)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic w, input logic [1:0] s,
                       input logic u, input logic [4:0] r,
                       input logic [31:0] a, input logic [31:0] d);
    valid = 1'b1;
    we    = w;
    size  = s;
    uns   = u;
    rd    = r;
    addr  = a;
    wdata = d;
    step();
    valid = 1'b0;
  endtask

  // Hold req for gdel cycles, grant, then respond one cycle later.
  task automatic bus_txn(input int gdel, input logic w,
                         input logic [3:0] be, input logic [31:0] a,
                         input logic [31:0] d, input logic [31:0] rsp,
                         input logic e);
    for (int i = 0; i <= gdel; i++) begin
      chk("req_hold", {31'b0, mem.req}, 32'd1);
      chk("we", {31'b0, mem.we}, {31'b0, w});
      chk("be", {28'b0, mem.be}, {28'b0, be});
      chk("addr", mem.addr, a);
      chk("wdata", mem.wdata, d);
      if (i < gdel) step();
    end
    mem.gnt = 1'b1;
    step();
    mem.gnt = 1'b0;
    chk("req_drop", {31'b0, mem.req}, 32'd0);
    chk("done_early", {31'b0, done}, 32'd0);
    mem.rvalid = 1'b1;
    mem.rdata  = rsp;
    mem.err    = e;
    step();
    mem.rvalid = 1'b0;
    mem.err    = 1'b0;
    mem.rdata  = 32'h0;
  endtask

  initial begin
    rstn       = 1'b0;
    valid      = 1'b0;
    we         = 1'b0;
    size       = 2'b00;
    uns        = 1'b0;
    rd         = 5'd0;
    addr       = 32'h0;
    wdata      = 32'h0;
    mem.gnt    = 1'b0;
    mem.rvalid = 1'b0;
    mem.rdata  = 32'h0;
    mem.err    = 1'b0;
    #2;
    chk("rst_ready", {31'b0, ready}, 32'd1);
    chk("rst_req", {31'b0, mem.req}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_rdata", rdata, 32'h0);
    step();
    rstn = 1'b1;
    step();

    // Load word 0x100, immediate grant
    issue(1'b0, 2'b10, 1'b0, 5'd5, 32'h100, 32'h0);
    chk("lw_ready_busy", {31'b0, ready}, 32'd0);
    bus_txn(0, 1'b0, 4'b1111, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0);
    chk("lw_done", {31'b0, done}, 32'd1);
    chk("lw_valid", {31'b0, rvalid_wb}, 32'd1);
    chk("lw_rdata", rdata, 32'hDEADBEEF);
    chk("lw_rd", {27'b0, rd_addr}, 32'd5);
    chk("lw_ready_b2b", {31'b0, ready}, 32'd1);

    // Back-to-back: signed byte at 0x103
    issue(1'b0, 2'b00, 1'b0, 5'd7, 32'h103, 32'h0);
    chk("lw_done_pulse", {31'b0, done}, 32'd0);
    bus_txn(0, 1'b0, 4'b1000, 32'h100, 32'h0, 32'h80FF0000, 1'b0);
    chk("lb_valid", {31'b0, rvalid_wb}, 32'd1);
    chk("lb_rdata", rdata, 32'hFFFFFF80);
    chk("lb_rd", {27'b0, rd_addr}, 32'd7);

    // Unsigned byte at 0x103
    issue(1'b0, 2'b00, 1'b1, 5'd8, 32'h103, 32'h0);
    bus_txn(1, 1'b0, 4'b1000, 32'h100, 32'h0, 32'h80FF0000, 1'b0);
    chk("lbu_rdata", rdata, 32'h00000080);

    // Signed half at 0x102
    issue(1'b0, 2'b01, 1'b0, 5'd9, 32'h102, 32'h0);
    bus_txn(0, 1'b0, 4'b1100, 32'h100, 32'h0, 32'h80011234, 1'b0);
    chk("lh_rdata", rdata, 32'hFFFF8001);

    // Store half 0x202, grant after 3 cycles
    issue(1'b1, 2'b01, 1'b0, 5'd0, 32'h202, 32'h1234ABCD);
    bus_txn(3, 1'b1, 4'b1100, 32'h200, 32'hABCDABCD, 32'h0, 1'b0);
    chk("sh_done", {31'b0, done}, 32'd1);
    chk("sh_valid", {31'b0, rvalid_wb}, 32'd0);

    // Store byte 0x301
    issue(1'b1, 2'b00, 1'b0, 5'd0, 32'h301, 32'h000000A5);
    bus_txn(0, 1'b1, 4'b0010, 32'h300, 32'hA5A5A5A5, 32'h0, 1'b0);
    chk("sb_done", {31'b0, done}, 32'd1);

    // Misaligned word load
    issue(1'b0, 2'b10, 1'b0, 5'd3, 32'h101, 32'h0);
    chk("mis_pulse", {31'b0, misal}, 32'd1);
    chk("mis_req", {31'b0, mem.req}, 32'd0);
    chk("mis_ready", {31'b0, ready}, 32'd1);
    step();
    chk("mis_once", {31'b0, misal}, 32'd0);
    chk("mis_noreq", {31'b0, mem.req}, 32'd0);

    // Illegal size
    issue(1'b0, 2'b11, 1'b0, 5'd3, 32'h100, 32'h0);
    chk("bad_size", {31'b0, misal}, 32'd1);
    chk("bad_size_req", {31'b0, mem.req}, 32'd0);

    // Bus error on load
    issue(1'b0, 2'b10, 1'b0, 5'd4, 32'h400, 32'h0);
    bus_txn(0, 1'b0, 4'b1111, 32'h400, 32'h0, 32'h12345678, 1'b1);
    chk("err_done", {31'b0, done}, 32'd1);
    chk("err_pulse", {31'b0, berr}, 32'd1);
    chk("err_valid", {31'b0, rvalid_wb}, 32'd0);
    step();
    chk("err_once", {31'b0, berr}, 32'd0);

    // Reset while waiting for response
    issue(1'b0, 2'b10, 1'b0, 5'd6, 32'h500, 32'h0);
    mem.gnt = 1'b1;
    step();
    mem.gnt = 1'b0;
    chk("resp_busy", {31'b0, ready}, 32'd0);
    #2;
    rstn = 1'b0;
    #1;
    chk("arst_req", {31'b0, mem.req}, 32'd0);
    chk("arst_ready", {31'b0, ready}, 32'd1);
    #1;
    rstn = 1'b1;
    mem.rvalid = 1'b1;
    mem.rdata  = 32'hCAFEF00D;
    step();
    mem.rvalid = 1'b0;
    chk("late_done", {31'b0, done}, 32'd0);
    chk("late_valid", {31'b0, rvalid_wb}, 32'd0);
    chk("late_ready", {31'b0, ready}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: observed no end expected finish");
    $fatal(1, "timeout");
  end

endmodule
